// File: rtl/jtag_ocimem_access.sv
// Sysclk-side debug memory engine: decodes JTAG ocimem strobes into single-word
// Avalon-MM reads/writes and reports the result through MonDReg/ready/error.
module jtag_ocimem_access #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy,
    output logic [ADDR_W+1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_inc_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              inc_q;
    logic [31:0]       mondreg_q;
    logic              ready_q;
    logic              error_q;
    logic              busy_q;
    logic              read_q;
    logic              write_q;
    logic [31:0]       wdata_q;
    logic              any_strobe_d;
    logic              unused_jdo;

    assign addr_inc_d   = addr_q + 1'b1;
    assign any_strobe_d = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign unused_jdo   = ^{jdo[37:36], jdo[2:0]};

    assign MonDReg        = mondreg_q;
    assign monitor_ready  = ready_q;
    assign monitor_error  = error_q;
    assign busy           = busy_q;
    assign avm_address    = {addr_q, 2'b00};
    assign avm_read       = read_q;
    assign avm_write      = write_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = 4'hF;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            inc_q     <= 1'b0;
            mondreg_q <= '0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (take_action_ocimem_b) begin
                        wdata_q   <= jdo[34:3];
                        mondreg_q <= jdo[34:3];
                        write_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        ready_q   <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= S_WR;
                    end else if (take_action_ocimem_a) begin
                        addr_q <= jdo[17 +: ADDR_W];
                        if (jdo[34]) begin
                            error_q <= 1'b0;
                        end
                        if (jdo[35]) begin
                            read_q  <= 1'b1;
                            busy_q  <= 1'b1;
                            ready_q <= 1'b0;
                            cnt_q   <= '0;
                            inc_q   <= 1'b0;
                            state_q <= S_RD;
                        end
                    end else if (take_no_action_ocimem_a) begin
                        read_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        cnt_q   <= '0;
                        inc_q   <= 1'b1;
                        state_q <= S_RD;
                    end
                end

                S_RD, S_WR: begin
                    // Commands are not queued; any strobe mid-access is an overrun.
                    if (any_strobe_d) begin
                        error_q <= 1'b1;
                    end
                    if (!avm_waitrequest) begin
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                        if (state_q == S_RD) begin
                            mondreg_q <= avm_readdata;
                        end
                        if (state_q == S_WR || inc_q) begin
                            addr_q <= addr_inc_d;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        // Abort: address and MonDReg keep their pre-access values.
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_ocimem_access.sv
// Scoreboard bench for jtag_ocimem_access: a reference model queues expected
// Avalon transactions, an independent monitor checks them as they complete.
module tb_jtag_ocimem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error, busy;
    logic [9:0]  avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    always #5 clk = ~clk;

    jtag_ocimem_access #(.ADDR_W(8), .TIMEOUT_CYC(255)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .busy                    (busy),
        .avm_address             (avm_address),
        .avm_read                (avm_read),
        .avm_write               (avm_write),
        .avm_writedata           (avm_writedata),
        .avm_byteenable          (avm_byteenable),
        .avm_readdata            (avm_readdata),
        .avm_waitrequest         (avm_waitrequest)
    );

    typedef struct {
        bit          is_wr;
        logic [9:0]  addr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] slave_mem [256];
    logic [31:0] ref_mem   [256];
    logic [7:0]  ref_addr;
    logic        ref_err, ref_ready;
    logic [31:0] ref_mond;
    int          wait_mode;   // 0: zero-wait, 1: random stalls, 2: stuck stall
    int          vectors = 0;
    int          errors  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave: waitrequest and readdata change just after the rising edge.
    initial begin
        avm_waitrequest = 1'b0;
        avm_readdata    = '0;
        forever begin
            @(posedge clk);
            #1;
            case (wait_mode)
                0:       avm_waitrequest = 1'b0;
                1:       avm_waitrequest = ($urandom_range(0, 3) == 0);
                default: avm_waitrequest = 1'b1;
            endcase
            avm_readdata = slave_mem[avm_address[9:2]];
        end
    end

    // Monitor: pops the scoreboard at every accepted Avalon transfer.
    logic        mon_chk_next = 1'b0;
    logic [31:0] mon_exp_mond;
    txn_t        mon_t;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_chk_next) begin
                chk("ready_after_xfer", monitor_ready, 1);
                chk("mondreg_after_xfer", MonDReg, mon_exp_mond);
                mon_chk_next = 1'b0;
            end
            if (!reset && (avm_read || avm_write)) begin
                chk("req_ready_busy", {avm_read & avm_write, monitor_ready, busy}, 3'b001);
                if (!avm_waitrequest) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL unexpected_xfer: got rd=%0b wr=%0b addr=%0h expected none",
                                 avm_read, avm_write, avm_address);
                    end else begin
                        mon_t = exp_q.pop_front();
                        chk("xfer_kind", avm_write, mon_t.is_wr);
                        chk("xfer_addr", avm_address, mon_t.addr);
                        if (mon_t.is_wr) begin
                            chk("xfer_wdata", avm_writedata, mon_t.data);
                            slave_mem[avm_address[9:2]] = avm_writedata;
                        end
                        mon_exp_mond = mon_t.data;
                        mon_chk_next = 1'b1;
                    end
                end
            end
        end
    end

    function automatic logic [37:0] mk_jdo(input bit b35, input bit b34,
                                           input logic [7:0] a, input logic [31:0] d, input bit wr);
        logic [63:0] r;
        logic [37:0] j;
        r = {$urandom, $urandom};
        j = r[37:0];
        if (wr) begin
            j[34:3] = d;
        end else begin
            j[35]    = b35;
            j[34]    = b34;
            j[24:17] = a;
        end
        return j;
    endfunction

    // Reference model: applies one accepted command using the strobe priority rules.
    task automatic model_cmd(input bit a, input bit na, input bit b, input logic [37:0] j);
        txn_t t;
        if (b) begin
            t = '{1'b1, {ref_addr, 2'b00}, j[34:3]};
            exp_q.push_back(t);
            ref_mem[ref_addr] = j[34:3];
            ref_mond  = j[34:3];
            ref_ready = 1'b1;
            ref_addr  = ref_addr + 8'd1;
        end else if (a) begin
            ref_addr = j[24:17];
            if (j[34]) ref_err = 1'b0;
            if (j[35]) begin
                t = '{1'b0, {ref_addr, 2'b00}, ref_mem[ref_addr]};
                exp_q.push_back(t);
                ref_mond  = ref_mem[ref_addr];
                ref_ready = 1'b1;
            end
        end else if (na) begin
            t = '{1'b0, {ref_addr, 2'b00}, ref_mem[ref_addr]};
            exp_q.push_back(t);
            ref_mond  = ref_mem[ref_addr];
            ref_ready = 1'b1;
            ref_addr  = ref_addr + 8'd1;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the strobe is sampled.
    task automatic strobe(input bit a, input bit na, input bit b, input logic [37:0] j);
        jdo                     = j;
        take_action_ocimem_a    = a;
        take_no_action_ocimem_a = na;
        take_action_ocimem_b    = b;
        @(negedge clk);
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
    endtask

    task automatic finish_op();
        int n = 0;
        while (busy && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            vectors++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 after %0d cycles expected busy=0", n);
        end
        chk("idle_addr", avm_address, {ref_addr, 2'b00});
        chk("idle_error", monitor_error, ref_err);
        chk("idle_ready", monitor_ready, ref_ready);
        chk("idle_mondreg", MonDReg, ref_mond);
        chk("idle_sb_empty", exp_q.size(), 0);
    endtask

    task automatic cmd(input bit a, input bit na, input bit b, input logic [37:0] j);
        model_cmd(a, na, b, j);
        strobe(a, na, b, j);
        finish_op();
    endtask

    initial begin
        logic [37:0] j;
        logic [7:0]  ra;
        int          n;
        bit          a, na, b;
        int          op;

        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        wait_mode = 0;
        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = $urandom;
            ref_mem[i]   = slave_mem[i];
        end
        ref_addr = '0; ref_err = 1'b0; ref_ready = 1'b0; ref_mond = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {MonDReg, monitor_ready, monitor_error, busy, avm_read, avm_write},
            {32'h0, 5'b0});
        chk("reset_wdata_addr", {avm_writedata, avm_address}, {32'h0, 10'h0});
        chk("byteenable", avm_byteenable, 4'hF);
        reset = 1'b0;
        @(negedge clk);

        // Zero-wait read via action_a with exact latency.
        slave_mem[8'h10] = 32'hDEADBEEF;
        ref_mem[8'h10]   = 32'hDEADBEEF;
        j = mk_jdo(1'b1, 1'b0, 8'h10, 32'h0, 1'b0);
        model_cmd(1'b1, 1'b0, 1'b0, j);
        chk("lat_pre_ready", monitor_ready, 0);
        strobe(1'b1, 1'b0, 1'b0, j);
        chk("lat_req_n1", {avm_read, avm_address}, {1'b1, 10'h040});
        @(negedge clk);
        chk("lat_done_n2", {monitor_ready, MonDReg}, {1'b1, 32'hDEADBEEF});
        finish_op();

        // Write at top address wraps the pointer.
        cmd(1'b1, 1'b0, 1'b0, mk_jdo(1'b0, 1'b0, 8'hFF, 32'h0, 1'b0));
        cmd(1'b0, 1'b0, 1'b1, mk_jdo(1'b0, 1'b0, 8'h0, 32'h12345678, 1'b1));
        chk("wrap_addr", avm_address, 10'h000);

        // Three post-incrementing reads from 0x20.
        cmd(1'b1, 1'b0, 1'b0, mk_jdo(1'b0, 1'b0, 8'h20, 32'h0, 1'b0));
        repeat (3) cmd(1'b0, 1'b1, 1'b0, 38'h0);
        chk("seq_final_addr", avm_address, {8'h23, 2'b00});

        // Stuck waitrequest on a read: abort after the timeout.
        wait_mode = 2;
        ra = 8'($urandom);
        j = mk_jdo(1'b1, 1'b0, ra, 32'h0, 1'b0);
        ref_addr = ra;
        strobe(1'b1, 1'b0, 1'b0, j);
        n = 0;
        while (avm_read && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_cycles", n, 255);
        ref_err = 1'b1;
        ref_ready = 1'b1;
        wait_mode = 0;
        finish_op();
        cmd(1'b1, 1'b0, 1'b0, mk_jdo(1'b0, 1'b1, ra, 32'h0, 1'b0));
        chk("error_cleared", monitor_error, 0);

        // Overrun: second write during a stall is dropped, first completes.
        wait_mode = 2;
        j = mk_jdo(1'b0, 1'b0, 8'h0, $urandom, 1'b1);
        model_cmd(1'b0, 1'b0, 1'b1, j);
        strobe(1'b0, 1'b0, 1'b1, j);
        @(negedge clk);
        strobe(1'b0, 1'b0, 1'b1, mk_jdo(1'b0, 1'b0, 8'h0, ~j[34:3], 1'b1));
        ref_err = 1'b1;
        repeat (2) @(negedge clk);
        wait_mode = 0;
        finish_op();
        cmd(1'b1, 1'b0, 1'b0, mk_jdo(1'b0, 1'b1, ref_addr, 32'h0, 1'b0));

        // Randomized mix with random stalls and occasional simultaneous strobes.
        wait_mode = 1;
        for (int k = 0; k < 200; k++) begin
            op = $urandom_range(0, 2);
            a  = (op == 0) || ($urandom_range(0, 7) == 0);
            na = (op == 1) || ($urandom_range(0, 7) == 0);
            b  = (op == 2) || ($urandom_range(0, 7) == 0);
            j  = mk_jdo($urandom_range(0, 1), ($urandom_range(0, 3) == 0), 8'($urandom),
                        $urandom, b);
            if (b && a) j[35:34] = 2'($urandom);
            cmd(a, na, b, j);
        end

        // Reset in the middle of a stalled write.
        wait_mode = 2;
        strobe(1'b0, 1'b0, 1'b1, mk_jdo(1'b0, 1'b0, 8'h0, $urandom, 1'b1));
        repeat (2) @(negedge clk);
        chk("pre_reset_write", avm_write, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", {MonDReg, monitor_ready, monitor_error, busy, avm_read, avm_write},
            {32'h0, 5'b0});
        chk("midreset_wdata_addr", {avm_writedata, avm_address}, {32'h0, 10'h0});
        reset = 1'b0;
        wait_mode = 0;
        ref_addr = '0; ref_err = 1'b0; ref_ready = 1'b0; ref_mond = '0;
        @(negedge clk);
        cmd(1'b0, 1'b1, 1'b0, 38'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
